// File: rtl/pdec_pkg.sv
// Shared constants and types for the polar decoder path-metric datapath.
// Candidate numbering is path*NUM_BR + branch throughout.
package pdec_pkg;

  localparam int NUM_PATH = 8;
  localparam int NUM_BR   = 4;
  localparam int NUM_CAND = 32;
  localparam int IDX_W    = 5;

  localparam logic [1:0] PATH_CK  = 2'b00;
  localparam logic [1:0] PATH_VLD = 2'b01;
  localparam logic [1:0] PATH_INV = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SORT = 1'b1
  } srt_state_e;

endpackage

// File: rtl/pdec_min_tree.sv
// Combinational 32-input masked argmin, 5-level binary tree.
// On equal PM the lower-index (left) child wins.
module pdec_min_tree
  import pdec_pkg::*;
#(
  parameter int WID_PM = 10
) (
  input  logic [WID_PM*NUM_CAND-1:0] i_pm,
  input  logic [NUM_CAND-1:0]        i_mask,
  output logic [WID_PM-1:0]          o_pm,
  output logic [IDX_W-1:0]           o_idx,
  output logic                       o_any
);

  logic              w_any [6][NUM_CAND];
  logic [WID_PM-1:0] w_pm  [6][NUM_CAND];
  logic [IDX_W-1:0]  w_idx [6][NUM_CAND];
  logic              w_r;

  always_comb begin
    w_r = 1'b0;
    for (int l = 0; l < 6; l++) begin
      for (int n = 0; n < NUM_CAND; n++) begin
        w_any[l][n] = 1'b0;
        w_pm[l][n]  = '0;
        w_idx[l][n] = '0;
      end
    end
    for (int n = 0; n < NUM_CAND; n++) begin
      w_any[0][n] = i_mask[n];
      w_pm[0][n]  = i_pm[n*WID_PM +: WID_PM];
      w_idx[0][n] = IDX_W'(n);
    end
    for (int l = 1; l < 6; l++) begin
      for (int n = 0; n < (NUM_CAND >> l); n++) begin
        // right child only wins on a strictly smaller PM
        w_r = w_any[l-1][2*n+1] &&
              (!w_any[l-1][2*n] ||
               (w_pm[l-1][2*n+1] < w_pm[l-1][2*n]));
        w_any[l][n] = w_any[l-1][2*n] | w_any[l-1][2*n+1];
        if (w_r) begin
          w_pm[l][n]  = w_pm[l-1][2*n+1];
          w_idx[l][n] = w_idx[l-1][2*n+1];
        end else begin
          w_pm[l][n]  = w_pm[l-1][2*n];
          w_idx[l][n] = w_idx[l-1][2*n];
        end
      end
    end
  end

  assign o_any = w_any[5][0];
  assign o_pm  = w_pm[5][0];
  assign o_idx = w_idx[5][0];

endmodule

// File: rtl/pdec_pm_sort.sv
// Survivor selection: picks the 8 smallest candidate PMs, one per cycle,
// and reports survivor PMs and their {path, branch} origins.
module pdec_pm_sort
  import pdec_pkg::*;
#(
  parameter int WID_PM   = 10,
  parameter int NUM_SURV = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       srt_start,
  input  logic                       cand_mode,
  input  logic [2*NUM_PATH-1:0]      path_valid,
  input  logic [WID_PM*NUM_CAND-1:0] upm2srt_pm_val,
  output logic [WID_PM*NUM_SURV-1:0] srt2upm_pm_val,
  output logic [IDX_W*NUM_SURV-1:0]  srt2uph_idx,
  output logic [NUM_SURV-1:0]        srt_vld,
  output logic                       srt_done,
  output logic                       srt_busy,
  output logic                       srt_ovf,
  output logic                       pdec_clk_en4
);

  if (NUM_SURV != 8) begin : g_bad_surv
    $error("pdec_pm_sort supports NUM_SURV == 8 only");
  end

  srt_state_e                 r_state;
  logic [WID_PM*NUM_CAND-1:0] r_pm;
  logic [NUM_CAND-1:0]        r_mask;
  logic [2:0]                 r_slot;
  logic [WID_PM-1:0]          r_spm  [NUM_SURV];
  logic [IDX_W-1:0]           r_sidx [NUM_SURV];
  logic [NUM_SURV-1:0]        r_vld;
  logic                       r_done;
  logic                       r_busy;
  logic                       r_ovf;

  logic [NUM_CAND-1:0] w_cap_mask;
  logic [WID_PM-1:0]   w_min_pm;
  logic [IDX_W-1:0]    w_min_idx;
  logic                w_min_any;

  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_mask
    logic [1:0] w_code;
    assign w_code = path_valid[(gi/NUM_BR)*2 +: 2];
    assign w_cap_mask[gi] =
      ((w_code == PATH_CK) || (w_code == PATH_VLD)) &&
      (cand_mode || ((gi % NUM_BR) < 2));
  end

  pdec_min_tree #(
    .WID_PM (WID_PM)
  ) u_min_tree (
    .i_pm   (r_pm),
    .i_mask (r_mask),
    .o_pm   (w_min_pm),
    .o_idx  (w_min_idx),
    .o_any  (w_min_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pm    <= '0;
      r_mask  <= '0;
      r_slot  <= '0;
      r_vld   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int s = 0; s < NUM_SURV; s++) begin
        r_spm[s]  <= '0;
        r_sidx[s] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (srt_start) begin
            r_pm    <= upm2srt_pm_val;
            r_mask  <= w_cap_mask;
            r_vld   <= '0;
            r_slot  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SORT;
          end
        end
        ST_SORT: begin
          if (srt_start) r_ovf <= 1'b1;
          if (w_min_any) begin
            r_spm[r_slot]     <= w_min_pm;
            r_sidx[r_slot]    <= w_min_idx;
            r_vld[r_slot]     <= 1'b1;
            r_mask[w_min_idx] <= 1'b0;
          end else begin
            r_spm[r_slot]  <= '1;
            r_sidx[r_slot] <= '0;
            r_vld[r_slot]  <= 1'b0;
          end
          if (r_slot == 3'd7) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_slot <= r_slot + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gs = 0; gs < NUM_SURV; gs++) begin : g_out
    assign srt2upm_pm_val[gs*WID_PM +: WID_PM] = r_spm[gs];
    assign srt2uph_idx[gs*IDX_W +: IDX_W]      = r_sidx[gs];
  end

  assign srt_vld      = r_vld;
  assign srt_done     = r_done;
  assign srt_busy     = r_busy;
  assign srt_ovf      = r_ovf;
  assign pdec_clk_en4 = srt_start | r_busy | r_done;

endmodule

// File: tb/tb_pdec_pm_sort.sv
// Directed bench for pdec_pm_sort: hand-computed survivor lists,
// overflow, back-to-back start and mid-sort reset.
module tb_pdec_pm_sort;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         srt_start = 1'b0;
  logic         cand_mode = 1'b0;
  logic [15:0]  path_valid = '0;
  logic [319:0] upm2srt_pm_val = '0;
  logic [79:0]  srt2upm_pm_val;
  logic [39:0]  srt2uph_idx;
  logic [7:0]   srt_vld;
  logic         srt_done;
  logic         srt_busy;
  logic         srt_ovf;
  logic         pdec_clk_en4;

  int n_err = 0;
  int n_chk = 0;

  pdec_pm_sort #(
    .WID_PM   (10),
    .NUM_SURV (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .srt_start      (srt_start),
    .cand_mode      (cand_mode),
    .path_valid     (path_valid),
    .upm2srt_pm_val (upm2srt_pm_val),
    .srt2upm_pm_val (srt2upm_pm_val),
    .srt2uph_idx    (srt2uph_idx),
    .srt_vld        (srt_vld),
    .srt_done       (srt_done),
    .srt_busy       (srt_busy),
    .srt_ovf        (srt_ovf),
    .pdec_clk_en4   (pdec_clk_en4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_slot(input int s, input int pm, input int idx,
                          input bit vld);
    chk($sformatf("pm[%0d]", s), 80'(srt2upm_pm_val[s*10 +: 10]),
        80'(pm));
    chk($sformatf("idx[%0d]", s), 80'(srt2uph_idx[s*5 +: 5]), 80'(idx));
    chk($sformatf("vld[%0d]", s), 80'(srt_vld[s]), 80'(vld));
  endtask

  task automatic set_pm_lin(input int mul, input int add);
    for (int i = 0; i < 32; i++)
      upm2srt_pm_val[i*10 +: 10] = 10'(i * mul + add);
  endtask

  // Called at a negedge; returns at the negedge where done should be high.
  task automatic run_sort(input int poke_k);
    srt_start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      srt_start = 1'b0;
      if (k > 0) begin
        chk($sformatf("done@%0d", k), 80'(srt_done), 80'(k == 8));
        chk($sformatf("busy@%0d", k), 80'(srt_busy), 80'(k < 8));
      end
      if (k == poke_k) begin
        srt_start  = 1'b1;
        path_valid = 16'hFFFF;
        set_pm_lin(0, 1);
      end
    end
  endtask

  initial begin
    #1;
    chk("rst_pm", 80'(srt2upm_pm_val), 80'(0));
    chk("rst_idx", 80'(srt2uph_idx), 80'(0));
    chk("rst_vld", 80'(srt_vld), 80'(0));
    chk("rst_flags", 80'({srt_done, srt_busy, srt_ovf, pdec_clk_en4}),
        80'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // all paths valid, 32 candidates, PM = 3*i
    path_valid = 16'h5555;
    cand_mode  = 1'b1;
    set_pm_lin(3, 0);
    run_sort(-1);
    chk("t1_clken_done", 80'(pdec_clk_en4), 80'(1));
    for (int s = 0; s < 8; s++) chk_slot(s, 3 * s, s, 1'b1);
    @(negedge clk);
    chk("t1_clken_idle", 80'(pdec_clk_en4), 80'(0));
    chk("t1_done_pulse", 80'(srt_done), 80'(0));

    // 16 candidates, PM = 31 - i
    cand_mode = 1'b0;
    set_pm_lin(-1, 31);
    run_sort(-1);
    begin
      int exp_idx[8] = '{29, 28, 25, 24, 21, 20, 17, 16};
      for (int s = 0; s < 8; s++)
        chk_slot(s, 31 - exp_idx[s], exp_idx[s], 1'b1);
    end

    // all ties
    cand_mode = 1'b1;
    set_pm_lin(0, 5);
    run_sort(-1);
    for (int s = 0; s < 8; s++) chk_slot(s, 5, s, 1'b1);

    // only path 0 valid
    path_valid = 16'hFFFD;
    set_pm_lin(3, 0);
    run_sort(-1);
    chk("t4_vld", 80'(srt_vld), 80'(8'h0F));
    for (int s = 0; s < 4; s++) chk_slot(s, 3 * s, s, 1'b1);
    for (int s = 4; s < 8; s++) chk_slot(s, 10'h3FF, 0, 1'b0);
    chk("t4_ovf", 80'(srt_ovf), 80'(0));

    // start while busy, inputs scrambled mid-sort
    path_valid = 16'h5555;
    set_pm_lin(3, 0);
    run_sort(2);
    for (int s = 0; s < 8; s++) chk_slot(s, 3 * s, s, 1'b1);
    chk("t5_ovf", 80'(srt_ovf), 80'(1));

    // back-to-back: second start in the done cycle
    path_valid = 16'h5555;
    cand_mode  = 1'b1;
    set_pm_lin(3, 0);
    run_sort(-1);
    chk_slot(7, 21, 7, 1'b1);
    set_pm_lin(-1, 31);
    run_sort(-1);
    for (int s = 0; s < 8; s++) chk_slot(s, s, 31 - s, 1'b1);
    chk("t6_ovf_sticky", 80'(srt_ovf), 80'(1));

    // reset mid-sort
    set_pm_lin(3, 0);
    srt_start = 1'b1;
    @(negedge clk);
    srt_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_busy_pre", 80'(srt_busy), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("t7_pm", 80'(srt2upm_pm_val), 80'(0));
    chk("t7_idx", 80'(srt2uph_idx), 80'(0));
    chk("t7_vld", 80'(srt_vld), 80'(0));
    chk("t7_flags",
        80'({srt_done, srt_busy, srt_ovf, pdec_clk_en4}), 80'(0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      chk($sformatf("t7_nodone@%0d", k), 80'(srt_done), 80'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
